// File: rtl/ex_stage_if.sv
// ex_stage_if -- bundles the decode->EX, EX->MEM, EX->decode and data-SRAM
// signals of the execute stage.
//   master : the surrounding pipeline; drives MEM_allow, ID_to_EX_valid and
//            ID_to_EX_bus, and observes everything else.
//   slave  : the execute stage itself.
interface ex_stage_if;
  logic         MEM_allow;
  logic         EX_allow;
  logic         ID_to_EX_valid;
  logic [147:0] ID_to_EX_bus;
  logic         EX_to_MEM_valid;
  logic [70:0]  EX_to_MEM_bus;
  logic [37:0]  EX_to_ID_forward;
  logic         EX_to_ID_load_up;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  modport master (
    output MEM_allow, ID_to_EX_valid, ID_to_EX_bus,
    input  EX_allow, EX_to_MEM_valid, EX_to_MEM_bus, EX_to_ID_forward,
           EX_to_ID_load_up, data_sram_en, data_sram_we, data_sram_addr,
           data_sram_wdata
  );

  modport slave (
    input  MEM_allow, ID_to_EX_valid, ID_to_EX_bus,
    output EX_allow, EX_to_MEM_valid, EX_to_MEM_bus, EX_to_ID_forward,
           EX_to_ID_load_up, data_sram_en, data_sram_we, data_sram_addr,
           data_sram_wdata
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage -- single-cycle execute stage of the pipeline.
// Latches one decoded instruction, evaluates the one-hot ALU, issues the
// data-SRAM request on the cycle the instruction moves on to MEM, and
// forwards its result back to decode.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high; clears the valid bit only
//   ex_if  : ex_stage_if.slave -- handshakes, pipeline buses, SRAM request
module ex_stage (
  input  logic       clk,
  input  logic       reset,
  ex_stage_if.slave  ex_if
);

  logic         ex_valid_q;
  logic         ex_valid_d;
  logic [147:0] bus_q;
  logic         ex_ready_go;
  logic         load_en;

  logic [11:0]  alu_op;
  logic [31:0]  src1;
  logic [31:0]  src2;
  logic         gr_we;
  logic         mem_we;
  logic [4:0]   dest;
  logic [31:0]  rkd_value;
  logic [31:0]  pc;
  logic         res_from_mem;
  logic [31:0]  alu_result;
  logic [4:0]   shamt;

  assign {alu_op, src1, src2, gr_we, mem_we, dest, rkd_value, pc, res_from_mem} = bus_q;
  assign shamt = src2[4:0];

  assign ex_ready_go   = 1'b1;
  assign ex_if.EX_allow = !ex_valid_q || (ex_ready_go && ex_if.MEM_allow);
  assign load_en       = ex_if.ID_to_EX_valid && ex_if.EX_allow;
  assign ex_valid_d    = ex_if.EX_allow ? ex_if.ID_to_EX_valid : ex_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
    end
    // Payload is deliberately not reset; it is ignored while ex_valid_q is 0.
    if (load_en) begin
      bus_q <= ex_if.ID_to_EX_bus;
    end
  end

  // Every selected term is OR-ed in, so an all-zero opcode yields 0.
  always_comb begin
    alu_result = '0;
    if (alu_op[0])  alu_result = alu_result | (src1 + src2);
    if (alu_op[1])  alu_result = alu_result | (src1 - src2);
    if (alu_op[2])  alu_result = alu_result | {31'd0, $signed(src1) < $signed(src2)};
    if (alu_op[3])  alu_result = alu_result | {31'd0, src1 < src2};
    if (alu_op[4])  alu_result = alu_result | (src1 & src2);
    if (alu_op[5])  alu_result = alu_result | ~(src1 | src2);
    if (alu_op[6])  alu_result = alu_result | (src1 | src2);
    if (alu_op[7])  alu_result = alu_result | (src1 ^ src2);
    if (alu_op[8])  alu_result = alu_result | (src1 << shamt);
    if (alu_op[9])  alu_result = alu_result | (src1 >> shamt);
    if (alu_op[10]) alu_result = alu_result | 32'($signed(src1) >>> shamt);
    if (alu_op[11]) alu_result = alu_result | src2;
  end

  assign ex_if.EX_to_MEM_valid = ex_valid_q && ex_ready_go;
  assign ex_if.EX_to_MEM_bus   = {res_from_mem, gr_we, dest, alu_result, pc};

  // Request only in the hand-off cycle, so a stalled access is never repeated.
  assign ex_if.data_sram_en    = ex_valid_q && ex_if.MEM_allow && (res_from_mem || mem_we);
  assign ex_if.data_sram_we    = (ex_if.data_sram_en && mem_we) ? 4'hF : 4'h0;
  assign ex_if.data_sram_addr  = alu_result;
  assign ex_if.data_sram_wdata = rkd_value;

  // A bubble forwards dest 0 so decode never sees a false dependency.
  assign ex_if.EX_to_ID_forward = {ex_valid_q && gr_we && !res_from_mem,
                                   (ex_valid_q && gr_we) ? dest : 5'd0,
                                   alu_result};
  assign ex_if.EX_to_ID_load_up = ex_valid_q && res_from_mem;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  ex_stage_if ex_if ();

  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .ex_if (ex_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [11:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] res;
  } alu_vec_t;

  alu_vec_t vec [15];

  function automatic logic [147:0] mk_bus(logic [11:0] op, logic [31:0] s1, logic [31:0] s2,
                                          logic gw, logic mw, logic [4:0] d,
                                          logic [31:0] rkd, logic [31:0] pc, logic rfm);
    return {op, s1, s2, gw, mw, d, rkd, pc, rfm};
  endfunction

  task automatic check(string name, logic [71:0] act, logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    vec[0]  = '{"add_ovf",  12'h001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    vec[1]  = '{"add_wrap", 12'h001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    vec[2]  = '{"sub",      12'h002, 32'h00000005, 32'h00000007, 32'hFFFFFFFE};
    vec[3]  = '{"slt",      12'h004, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vec[4]  = '{"sltu",     12'h008, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vec[5]  = '{"and",      12'h010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vec[6]  = '{"nor",      12'h020, 32'h0F0F0000, 32'h000000F0, 32'hF0F0FF0F};
    vec[7]  = '{"or",       12'h040, 32'h12340000, 32'h00005678, 32'h12345678};
    vec[8]  = '{"xor",      12'h080, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555};
    vec[9]  = '{"sll",      12'h100, 32'h00000001, 32'h00000021, 32'h00000002};
    vec[10] = '{"srl",      12'h200, 32'h80000000, 32'h0000001F, 32'h00000001};
    vec[11] = '{"sra",      12'h400, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF};
    vec[12] = '{"lu12i",    12'h800, 32'h00000000, 32'hABCDE000, 32'hABCDE000};
    vec[13] = '{"zero_op",  12'h000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000};
    vec[14] = '{"multihot", 12'h050, 32'h0000000C, 32'h0000000A, 32'h0000000E};

    // Reset state
    reset = 1'b1;
    ex_if.MEM_allow      = 1'b1;
    ex_if.ID_to_EX_valid = 1'b0;
    ex_if.ID_to_EX_bus   = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_mem_valid", 72'(ex_if.EX_to_MEM_valid), 72'd0);
    check("rst_allow",     72'(ex_if.EX_allow), 72'd1);
    check("rst_sram_en",   72'(ex_if.data_sram_en), 72'd0);
    check("rst_sram_we",   72'(ex_if.data_sram_we), 72'd0);
    check("rst_fwd_we_dest", 72'(ex_if.EX_to_ID_forward[37:32]), 72'd0);
    check("rst_load_up",   72'(ex_if.EX_to_ID_load_up), 72'd0);

    // ALU table, issued back to back with no bubbles
    for (int i = 0; i < 15; i++) begin
      ex_if.ID_to_EX_valid = 1'b1;
      ex_if.ID_to_EX_bus   = mk_bus(vec[i].op, vec[i].s1, vec[i].s2, 1'b1, 1'b0,
                                    5'(i + 1), 32'h0, 32'h1C000000 + 32'(i * 4), 1'b0);
      tick();
      check({vec[i].name, "_valid"}, 72'(ex_if.EX_to_MEM_valid), 72'd1);
      check({vec[i].name, "_bus"}, 72'(ex_if.EX_to_MEM_bus),
            72'({1'b0, 1'b1, 5'(i + 1), vec[i].res, 32'h1C000000 + 32'(i * 4)}));
      check({vec[i].name, "_fwd"}, 72'(ex_if.EX_to_ID_forward),
            72'({1'b1, 5'(i + 1), vec[i].res}));
      check({vec[i].name, "_allow"}, 72'(ex_if.EX_allow), 72'd1);
      check({vec[i].name, "_en"}, 72'(ex_if.data_sram_en), 72'd0);
    end

    // ld.w
    ex_if.ID_to_EX_bus = mk_bus(12'h001, 32'h1000, 32'h8, 1'b1, 1'b0, 5'd4,
                                32'h0, 32'h1C000100, 1'b1);
    tick();
    check("ld_en",      72'(ex_if.data_sram_en), 72'd1);
    check("ld_we",      72'(ex_if.data_sram_we), 72'd0);
    check("ld_addr",    72'(ex_if.data_sram_addr), 72'h1008);
    check("ld_load_up", 72'(ex_if.EX_to_ID_load_up), 72'd1);
    check("ld_fwd_we",  72'(ex_if.EX_to_ID_forward[37]), 72'd0);
    check("ld_fwd_dest", 72'(ex_if.EX_to_ID_forward[36:32]), 72'd4);

    // st.w stalled three cycles; a waiting instruction must not be latched
    ex_if.ID_to_EX_bus = mk_bus(12'h001, 32'h2000, 32'h0, 1'b0, 1'b1, 5'd0,
                                32'hDEADBEEF, 32'h1C000104, 1'b0);
    tick();
    ex_if.MEM_allow      = 1'b0;
    ex_if.ID_to_EX_bus   = mk_bus(12'h001, 32'h5, 32'h5, 1'b1, 1'b0, 5'd9,
                                  32'h0, 32'h1C000108, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("st_stall_en",    72'(ex_if.data_sram_en), 72'd0);
      check("st_stall_allow", 72'(ex_if.EX_allow), 72'd0);
      check("st_stall_pc",    72'(ex_if.EX_to_MEM_bus[31:0]), 72'h1C000104);
      check("st_stall_fwd_dest", 72'(ex_if.EX_to_ID_forward[36:32]), 72'd0);
      tick();
    end
    ex_if.MEM_allow      = 1'b1;
    ex_if.ID_to_EX_valid = 1'b0;
    #1;
    check("st_en",    72'(ex_if.data_sram_en), 72'd1);
    check("st_we",    72'(ex_if.data_sram_we), 72'hF);
    check("st_addr",  72'(ex_if.data_sram_addr), 72'h2000);
    check("st_wdata", 72'(ex_if.data_sram_wdata), 72'hDEADBEEF);
    tick();
    check("st_after_en",    72'(ex_if.data_sram_en), 72'd0);
    check("st_after_valid", 72'(ex_if.EX_to_MEM_valid), 72'd0);
    check("bubble_fwd_dest", 72'(ex_if.EX_to_ID_forward[36:32]), 72'd0);

    // Reset during a stall drops the held load with no SRAM access
    ex_if.ID_to_EX_valid = 1'b1;
    ex_if.ID_to_EX_bus   = mk_bus(12'h001, 32'h3000, 32'h4, 1'b1, 1'b0, 5'd7,
                                  32'h0, 32'h1C000200, 1'b1);
    tick();
    ex_if.ID_to_EX_valid = 1'b0;
    ex_if.MEM_allow      = 1'b0;
    #1;
    check("rs_stall_valid", 72'(ex_if.EX_to_MEM_valid), 72'd1);
    check("rs_stall_en",    72'(ex_if.data_sram_en), 72'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ex_if.MEM_allow = 1'b1;
    #1;
    check("rs_valid",   72'(ex_if.EX_to_MEM_valid), 72'd0);
    check("rs_en",      72'(ex_if.data_sram_en), 72'd0);
    check("rs_load_up", 72'(ex_if.EX_to_ID_load_up), 72'd0);
    check("rs_allow",   72'(ex_if.EX_allow), 72'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high.
REQ-003 MEM_allow  in  1  downstream stage can accept this cycle.
REQ-004 EX_allow  out  1  this stage can accept from decode this cycle.
REQ-005 ID_to_EX_valid  in  1  decode presents a valid instruction.
REQ-006 ID_to_EX_bus  in  148  fields, MSB first:
- alu_op[11:0]
- alu_src1[31:0]
- alu_src2[31:0]
- gr_we
- mem_we
- dest[4:0]
- rkd_value[31:0]
- pc[31:0]
- res_from_mem
REQ-007 EX_to_MEM_valid  out  1  valid instruction offered to MEM.
REQ-008 EX_to_MEM_bus  out  71  fields, MSB first: {res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}.
REQ-009 EX_to_ID_forward  out  38  {we, dest[4:0], result[31:0]}.
REQ-010 EX_to_ID_load_up  out  1  the instruction in EX is a valid load.
REQ-011 data_sram_en  out  1  data SRAM access enable.
REQ-012 data_sram_we  out  4  byte write enables.
REQ-013 data_sram_addr  out  32  byte address.
REQ-014 data_sram_wdata  out  32  store data.

Function
REQ-015 State SHALL be:
- EX_valid (1 bit)
- bus_reg (148 bits), loaded only when ID_to_EX_valid && EX_allow.
REQ-016 EX_valid SHALL load ID_to_EX_valid when EX_allow, and otherwise hold.
REQ-017 EX_ready_go SHALL be constant 1 (single-cycle ALU).
REQ-018 EX_allow SHALL be !EX_valid || (EX_ready_go && MEM_allow).
REQ-019 EX_to_MEM_valid SHALL be EX_valid && EX_ready_go.
REQ-020 ALU results, selected by one-hot alu_op (src1 = alu_src1, src2 = alu_src2):
- bit0: src1 + src2
- bit1: src1 - src2
- bit2: signed src1 < src2 ? 1 : 0
- bit3: unsigned src1 < src2 ? 1 : 0
- bit4: src1 & src2
- bit5: ~(src1 | src2)
- bit6: src1 | src2
- bit7: src1 ^ src2
- bit8: src1 << src2[4:0]
- bit9: src1 >> src2[4:0], logical
- bit10: src1 >> src2[4:0], arithmetic
- bit11: src2 (lu12i)
REQ-021 The final ALU result SHALL be the OR of all selected terms; all-zero alu_op SHALL give 0.
REQ-022 All arithmetic SHALL be 32-bit modulo; carry and overflow are discarded.
REQ-023 data_sram_en SHALL be 1 only when EX_valid && MEM_allow && (res_from_mem || mem_we); the request is issued exactly in the cycle the instruction moves to MEM, so a stalled instruction never re-issues.
REQ-024 data_sram_we SHALL be 4'hF when data_sram_en && mem_we, else 4'h0.
REQ-025 data_sram_addr SHALL be alu_result; data_sram_wdata SHALL be rkd_value.
REQ-026 Forward fields:
- we = EX_valid && gr_we && !res_from_mem
- dest = EX_valid && gr_we ? dest : 5'd0
- result = alu_result
REQ-027 EX_to_ID_load_up SHALL be EX_valid && res_from_mem.
REQ-028 When EX_valid=0, forward dest SHALL be 0 so that decode never stalls on a bubble.
REQ-029 Simultaneous accept and hand-off SHALL occur in one cycle: the old instruction goes to MEM and the new one is latched, with no bubble.
REQ-030 When MEM_allow=0 and EX_valid=1:
- bus_reg and EX_valid SHALL hold.
- EX_allow SHALL be 0.
- data_sram_en SHALL be 0.

Reset
REQ-031 On reset, EX_valid SHALL be 0. Consequently EX_to_MEM_valid=0, data_sram_en=0, data_sram_we=0, forward we=0 and forward dest=0, EX_to_ID_load_up=0, and EX_allow=1.
REQ-032 bus_reg SHALL NOT be reset; its contents SHALL be don't-care while EX_valid=0.
REQ-033 Reset asserted mid-stall SHALL drop the held instruction on the next edge, with no SRAM access.

Verification
REQ-034 add.w: alu_op=bit0, src1=0x7FFFFFFF, src2=1, dest=5, gr_we=1, MEM_allow=1. Next cycle: alu_result=0x80000000, forward={1,5,0x80000000}, EX_to_MEM_valid=1.
REQ-035 sra: bit10, src1=0x80000000, src2=31. Result SHALL be 0xFFFFFFFF. With bit9 and the same operands, result SHALL be 0x00000001.
REQ-036 ld.w: res_from_mem=1, src1=0x1000, src2=8, dest=4. Required response:
- data_sram_en=1, we=0, addr=0x1008
- load_up=1
- forward we=0, forward dest=4
REQ-037 st.w: mem_we=1, gr_we=0, addr=0x2000, rkd=0xDEADBEEF, with MEM_allow=0 for 3 cycles, then 1:
- en=0 and EX_allow=0 during the stall.
- then exactly one cycle of en=1, we=4'hF, wdata=0xDEADBEEF.
REQ-038 Back-to-back valid instructions with MEM_allow=1 SHALL each appear on EX_to_MEM_bus in consecutive cycles. A reset pulse during a stall SHALL give EX_to_MEM_valid=0 on the next cycle.
